// File: rtl/hci_package.sv
// rtl/hci_package.sv - shared constants, types and LFSR step for the HCI memory bank
package hci_package;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef enum logic {
        WEN_WRITE = 1'b0,
        WEN_READ  = 1'b1
    } wen_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/hci_mem_bank_if.sv
// rtl/hci_mem_bank_if.sv - request/response bus between a requester and the memory bank
interface hci_mem_bank_if #(
    parameter int DW  = 32,
    parameter int AWM = 32,
    parameter int IW  = 8
) ();
    logic            req_i;
    logic            gnt_o;
    logic [AWM-1:0]  add_i;
    logic            wen_i;
    logic [DW/8-1:0] be_i;
    logic [DW-1:0]   data_i;
    logic [IW-1:0]   id_i;
    logic [DW-1:0]   r_data_o;
    logic            r_valid_o;
    logic [IW-1:0]   r_id_o;

    modport master (
        output req_i, add_i, wen_i, be_i, data_i, id_i,
        input  gnt_o, r_data_o, r_valid_o, r_id_o
    );

    modport slave (
        input  req_i, add_i, wen_i, be_i, data_i, id_i,
        output gnt_o, r_data_o, r_valid_o, r_id_o
    );
endinterface

// File: rtl/hci_mem_bank_array.sv
// rtl/hci_mem_bank_array.sv - unreset word storage with per-byte write enables
module hci_mem_bank_array #(
    parameter int DW       = 32,
    parameter int NB_WORDS = 1024,
    parameter int AW       = $clog2(NB_WORDS)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [DW-1:0]   wdata_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [NB_WORDS];

    // Contents are deliberately not reset; the read port is sampled by the top.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < DW/8; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/hci_mem_bank.sv
// rtl/hci_mem_bank.sv - single-port memory bank, latency-1 responses; HCI_MEM_BANK_STALL_EN adds an LFSR stall generator
module hci_mem_bank
    import hci_package::*;
#(
    parameter int          DW        = 32,
    parameter int          NB_WORDS  = 1024,
    parameter int          AWM       = 32,
    parameter int          IW        = 8,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    hci_mem_bank_if.slave bus
);

    localparam int OFFW = $clog2(DW/8);
    localparam int AW   = $clog2(NB_WORDS);

    logic [AWM-1:0] add;
    logic [AW-1:0]  idx;
    logic           stall;
    logic           hs;
    logic           is_read;
    logic [DW-1:0]  rdata;
    logic           unused_ok;

    logic           r_valid_q, r_valid_d;
    logic [IW-1:0]  r_id_q,    r_id_d;
    logic [DW-1:0]  r_data_q,  r_data_d;

    // Only the word-index bits matter; everything else wraps modulo NB_WORDS.
    assign add       = bus.add_i;
    assign idx       = add[OFFW +: AW];
    assign unused_ok = ^{add, LFSR_SEED};

`ifdef HCI_MEM_BANK_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        if (clear_i) begin
            lfsr_d = LFSR_SEED;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign bus.gnt_o = bus.req_i & ~stall;
    assign hs        = bus.req_i & bus.gnt_o;
    assign is_read   = (wen_e'(bus.wen_i) == WEN_READ);

    hci_mem_bank_array #(
        .DW       (DW),
        .NB_WORDS (NB_WORDS),
        .AW       (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (hs & ~is_read),
        .addr_i  (idx),
        .be_i    (bus.be_i),
        .wdata_i (bus.data_i),
        .rdata_o (rdata)
    );

    // A clear in the grant cycle drops the response but never blocks the write.
    always_comb begin
        r_valid_d = hs & ~clear_i;
        r_id_d    = r_id_q;
        r_data_d  = r_data_q;
        if (hs && !clear_i) begin
            r_id_d = bus.id_i;
            if (is_read) begin
                r_data_d = rdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= r_valid_d;
            r_id_q    <= r_id_d;
            r_data_q  <= r_data_d;
        end
    end

    assign bus.r_valid_o = r_valid_q;
    assign bus.r_id_o    = r_id_q;
    assign bus.r_data_o  = r_data_q;

endmodule

// File: tb/tb_hci_mem_bank.sv
// tb/tb_hci_mem_bank.sv - scoreboard bench for hci_mem_bank against a byte-level memory model
module tb_hci_mem_bank;

    localparam int DW       = 32;
    localparam int NBY      = DW / 8;
    localparam int NB_WORDS = 1024;
    localparam int AWM      = 32;
    localparam int IW       = 8;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int req_cycles = 0;
    int grant_cycles = 0;
    logic count_en = 1'b0;

    exp_t          sb[$];
    logic [7:0]    mem_m[int];
    logic [DW-1:0] last_rdata = '0;
    logic [DW-1:0] last_mask = '1;

    hci_mem_bank_if #(.DW(DW), .AWM(AWM), .IW(IW)) bus ();

    hci_mem_bank #(
        .DW        (DW),
        .NB_WORDS  (NB_WORDS),
        .AWM       (AWM),
        .IW        (IW),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one request, hold it until granted, update the model and queue the response.
    task automatic issue(input logic wen, input logic [AWM-1:0] add, input logic [NBY-1:0] be,
                         input logic [DW-1:0] data, input logic [IW-1:0] id, input logic clr);
        int   waited = 0;
        int   w;
        exp_t e;
        bus.req_i  = 1'b1;
        bus.wen_i  = wen;
        bus.add_i  = add;
        bus.be_i   = be;
        bus.data_i = data;
        bus.id_i   = id;
        clear      = clr;
        @(negedge clk);
        while (!bus.gnt_o && waited < 64) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.gnt_o) begin
            tests++;
            fails++;
            $display("FAIL grant_timeout: no grant after %0d cycles, expected a grant", waited);
        end else begin
            w = int'((add / NBY) % NB_WORDS);
            e.id  = id;
            e.cyc = cyc + 1;
            if (!wen) begin
                for (int b = 0; b < NBY; b++)
                    if (be[b]) mem_m[w*NBY + b] = data[b*8 +: 8];
                e.data = last_rdata;
                e.mask = last_mask;
            end else begin
                e.data = '0;
                e.mask = '0;
                for (int b = 0; b < NBY; b++)
                    if (mem_m.exists(w*NBY + b)) begin
                        e.data[b*8 +: 8] = mem_m[w*NBY + b];
                        e.mask[b*8 +: 8] = 8'hFF;
                    end
                if (!clr) begin
                    last_rdata = e.data;
                    last_mask  = e.mask;
                end
            end
            if (!clr) sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.req_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every presented response must match the oldest queued expectation, on time.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
`ifndef HCI_MEM_BANK_STALL_EN
            tests++;
            if (bus.gnt_o !== bus.req_i) begin
                fails++;
                $display("FAIL gnt_eq_req: gnt=%b expected %b", bus.gnt_o, bus.req_i);
            end
`endif
            if (count_en && bus.req_i) begin
                req_cycles++;
                if (bus.gnt_o) grant_cycles++;
            end
            if (bus.r_valid_o) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_rsp: r_valid=1 id=%h expected no response", bus.r_id_o);
                end else begin
                    e = sb.pop_front();
                    if (bus.r_id_o !== e.id || ((bus.r_data_o ^ e.data) & e.mask) != '0 || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL response: id=%h data=%h cyc=%0d expected id=%h data=%h mask=%h cyc=%0d",
                                 bus.r_id_o, bus.r_data_o, cyc, e.id, e.data, e.mask, e.cyc);
                    end
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_rsp: r_valid=0 expected id=%h at cyc %0d", sb[0].id, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        logic [AWM-1:0] a;
        logic [DW-1:0]  d;
        bus.req_i = 1'b0; bus.wen_i = 1'b0; bus.add_i = '0;
        bus.be_i = '0; bus.data_i = '0; bus.id_i = '0;

        #23;
        check("reset_r_valid", DW'(bus.r_valid_o), '0);
        check("reset_r_data", bus.r_data_o, '0);
        check("reset_r_id", DW'(bus.r_id_o), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Basic write/read at 0x10
        issue(1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 8'd3, 1'b0);
        issue(1'b1, 32'h10, 4'h0, 32'h0, 8'd4, 1'b0);
        idle(1);
        check("basic_read_data", bus.r_data_o, 32'hDEADBEEF);

        // Partial byte-enable merge
        issue(1'b0, 32'h20, 4'hF, 32'h11223344, 8'd5, 1'b0);
        issue(1'b0, 32'h20, 4'b0101, 32'hAABBCCDD, 8'd6, 1'b0);
        issue(1'b0, 32'h20, 4'b0000, 32'hFFFFFFFF, 8'd7, 1'b0);
        issue(1'b1, 32'h20, 4'h0, 32'h0, 8'd8, 1'b0);
        idle(1);
        check("byte_enable_merge", bus.r_data_o, 32'h11BB33DD);

        // Address wrap: 0x1000 aliases word 0
        issue(1'b0, 32'h1000, 4'hF, 32'hCAFEF00D, 8'd9, 1'b0);
        issue(1'b1, 32'h0000, 4'h0, 32'h0, 8'd10, 1'b0);
        idle(1);
        check("address_wrap", bus.r_data_o, 32'hCAFEF00D);

        // Back-to-back ids 0..7 with write-then-read of the same word
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) issue(1'b0, 32'h40 + 32'(i), 4'hF, 32'h5A000000 + 32'(i), 8'(i), 1'b0);
            else            issue(1'b1, 32'h40 + 32'(i - 1), 4'h0, 32'h0, 8'(i), 1'b0);
        end
        idle(2);

        // Clear in a grant cycle: no response, but the write lands
        issue(1'b0, 32'h80, 4'hF, 32'h0BADC0DE, 8'd20, 1'b1);
        idle(2);
        issue(1'b1, 32'h80, 4'h0, 32'h0, 8'd21, 1'b0);
        idle(1);
        check("clear_write_commits", bus.r_data_o, 32'h0BADC0DE);

        // Reset asserted with a read in flight drops the response
        idle(2);
        bus.req_i = 1'b1; bus.wen_i = 1'b1; bus.add_i = 32'h10; bus.id_i = 8'd30;
        @(negedge clk); #1;
        rst_n = 1'b0;
        bus.req_i = 1'b0;
        @(posedge clk); #1;
        check("midreset_r_valid", DW'(bus.r_valid_o), '0);
        check("midreset_r_data", bus.r_data_o, '0);
        #3;
        rst_n = 1'b1;
        last_rdata = '0;
        last_mask  = '1;
        idle(2);
        check("post_reset_r_valid", DW'(bus.r_valid_o), '0);

        // Randomized traffic with the request held high
        count_en = 1'b1;
        while (req_cycles < 1000) begin
            a = ($urandom << 12) | ((32'($urandom_range(0, 15))) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            issue(1'($urandom_range(0, 1)), a, 4'($urandom), d, 8'($urandom), 1'b0);
        end
        count_en = 1'b0;
        idle(3);

`ifdef HCI_MEM_BANK_STALL_EN
        tests++;
        if ((req_cycles - grant_cycles) * 100 < req_cycles * 20 ||
            (req_cycles - grant_cycles) * 100 > req_cycles * 30) begin
            fails++;
            $display("FAIL stall_rate: stalled %0d of %0d cycles, expected 20-30%%",
                     req_cycles - grant_cycles, req_cycles);
        end
`endif
        check("scoreboard_drained", DW'(sb.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hci_mem_bank.md
HCI_MEM_BANK -- requirements
Module: hci_mem_bank

Interface
REQ-001: Parameter DW, 32, data width in bits; multiple of 8.
REQ-002: Parameter NB_WORDS, 1024, bank depth in DW-bit words; power of two.
REQ-003: Parameter AWM, 32, width of the incoming byte address.
REQ-004: Parameter IW, 8, width of the request/response ID.
REQ-005: Parameter LFSR_SEED, 16'hACE1, reset seed of the stall generator; nonzero.
REQ-006: One clock, clk_i; reset is asynchronous and active-low, rst_ni.
REQ-007: clk_i  in  1  bank clock.
REQ-008: rst_ni  in  1  asynchronous active-low reset.
REQ-009: clear_i  in  1  synchronous clear of the response pipeline and the stall generator.
REQ-010: req_i  in  1  access request.
REQ-011: gnt_o  out  1  request accepted in this cycle.
REQ-012: add_i  in  AWM  byte address.
REQ-013: wen_i  in  1  1 = read, 0 = write.
REQ-014: be_i  in  DW/8  byte enables for writes.
REQ-015: data_i  in  DW  write data.
REQ-016: id_i  in  IW  requester ID.
REQ-017: r_data_o  out  DW  read data.
REQ-018: r_valid_o  out  1  response valid.
REQ-019: r_id_o  out  IW  ID echoed from the granted request.

Function
REQ-020: The word index SHALL be add_i[log2(DW/8) +: log2(NB_WORDS)]; all other address bits are ignored, so out-of-range addresses wrap modulo NB_WORDS.
REQ-021: gnt_o SHALL be combinational: req_i AND NOT stall.
REQ-022: stall SHALL be 0 when the stall feature is compiled out.
REQ-023: A handshake SHALL occur when req_i and gnt_o are both 1 in the same cycle.
REQ-024: For a granted write (wen_i=0), each byte b with be_i[b]=1 SHALL be updated at the clock edge ending the grant cycle; bytes with be_i[b]=0 keep their value.
REQ-025: For a granted read (wen_i=1), r_data_o SHALL present the word contents exactly one cycle after the grant (latency 1).
REQ-026: Every granted request, read or write, SHALL produce r_valid_o=1 for exactly one cycle, one cycle after the grant, with r_id_o equal to the granted id_i.
REQ-027: After a granted write, r_data_o SHALL hold its previous value.
REQ-028: Back-to-back grants SHALL produce back-to-back responses; there is no response backpressure.
REQ-029: A read in cycle N+1 of the word written in cycle N SHALL return the newly written data.
REQ-030: A write with be_i=0 SHALL leave memory unchanged but still respond (REQ-026).
REQ-031: When not granted, add_i, wen_i, be_i, data_i and id_i SHALL have no effect.
REQ-032: clear_i=1 SHALL force r_valid_o=0 in the next cycle, discard any in-flight response and reload the LFSR with LFSR_SEED; a write granted in the same cycle still commits.

Reset
REQ-033: On rst_ni=0, r_valid_o, r_data_o and r_id_o SHALL be 0 and the LFSR SHALL equal LFSR_SEED, all asynchronously.
REQ-034: Memory contents SHALL NOT be reset and are undefined until written.
REQ-035: A reset asserted mid-operation SHALL drop any pending response without producing r_valid_o.

Configuration
REQ-036: The macro HCI_MEM_BANK_STALL_EN SHALL compile in the stall generator.
REQ-037: With HCI_MEM_BANK_STALL_EN defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle, and stall SHALL be 1 when lfsr[1:0]==2'b00.
REQ-038: Without HCI_MEM_BANK_STALL_EN, the LFSR SHALL be absent and gnt_o SHALL equal req_i.

Structure
REQ-039: The LFSR polynomial, the default seed and the read/write encoding constants SHALL live in hci_package.
REQ-040: The storage array plus byte-enable write logic SHALL be one sub-module, hci_mem_bank_array; response pipeline and stall logic stay in the top.

Verification
REQ-041: Scenario: reset, then write 0xDEADBEEF with be=4'hF, id=3 to 0x10 -> next cycle r_valid_o=1, r_id_o=3; read 0x10 -> r_data_o=0xDEADBEEF one cycle after the grant.
REQ-042: Scenario: write 0x11223344 (be=F) to 0x20, then write 0xAABBCCDD with be=4'b0101 -> read 0x20 returns 0x11BB33DD.
REQ-043: Scenario: with NB_WORDS=1024, write to 0x1000 -> read 0x0000 returns the same data (wrap).
REQ-044: Scenario: 8 back-to-back grants with ids 0..7 -> r_valid_o high 8 consecutive cycles, ids 0..7 in order; write in cycle N, read same address in N+1 -> new data.
REQ-045: Scenario: clear_i pulsed in a grant cycle -> no r_valid_o the next cycle; a write in that cycle is readable afterward.
REQ-046: Scenario: HCI_MEM_BANK_STALL_EN defined, req_i held high 1000 cycles -> gnt_o low in 20-30% of cycles and exactly one response per grant; macro undefined -> gnt_o==req_i every cycle.
